// File: rtl/queue_pkg.sv
// Shared sizing helpers and the mod-depth pointer distance used by circular queues and tag consumers.
package queue_pkg;

  localparam int unsigned MAX_ADDR_WIDTH = 16;

  function automatic int unsigned depth_of(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  // Distance from from_ptr forward to to_ptr, modulo 2**aw.
  function automatic logic [MAX_ADDR_WIDTH-1:0] ptr_dist(input logic [MAX_ADDR_WIDTH-1:0] from_ptr,
                                                         input logic [MAX_ADDR_WIDTH-1:0] to_ptr,
                                                         input int unsigned aw);
    logic [MAX_ADDR_WIDTH-1:0] mask;
    mask = MAX_ADDR_WIDTH'((32'd1 << aw) - 32'd1);
    return (to_ptr - from_ptr) & mask;
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// Wrapping pointer register: clear beats load beats increment, all gated by the global enable.
module queue_ptr #(
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [ADDR_WIDTH-1:0] ld_val,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr <= '0;
    end else if (en) begin
      if (clr)      ptr <= '0;
      else if (ld)  ptr <= ld_val;
      else if (inc) ptr <= ptr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/circ_queue.sv
// Clocked circular FIFO with random-access slot read/write, flush and optional tail rollback.
// Define CIRC_QUEUE_TRUNCATE_EN to build the trunc_en/trunc_tail rollback path.
module circ_queue
  import queue_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0]   rd_idx,
  input  logic                    trunc_en,
  input  logic [ADDR_WIDTH-1:0]   trunc_tail,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [ADDR_WIDTH-1:0]   head_idx,
  output logic [ADDR_WIDTH-1:0]   tail_idx,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  push_acc;
  logic                  pop_acc;
  logic                  tail_ld;
  logic [ADDR_WIDTH-1:0] tail_ld_val;

`ifdef CIRC_QUEUE_TRUNCATE_EN
  logic                  trunc_go;
  logic [ADDR_WIDTH-1:0] head_next;
  logic [CNT_W-1:0]      count_trunc;

  // Rollback count is measured from the head as it will stand after this edge's pop.
  always_comb begin
    trunc_go    = trunc_en && !clear;
    head_next   = head_idx + ADDR_WIDTH'(pop_ok);
    count_trunc = CNT_W'(ptr_dist(MAX_ADDR_WIDTH'(head_next), MAX_ADDR_WIDTH'(trunc_tail), ADDR_WIDTH));
    tail_ld     = trunc_go;
    tail_ld_val = trunc_tail;
  end
`else
  logic unused_trunc;
  assign unused_trunc = ^{trunc_en, trunc_tail};
  assign tail_ld      = 1'b0;
  assign tail_ld_val  = '0;
`endif

  // Accept logic: a full queue still takes a push paired with a pop.
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    push_acc = push_ok && !clear && !tail_ld;
    pop_acc  = pop_ok && !clear;
    count_nxt = count_q;
    if (clear) begin
      count_nxt = '0;
`ifdef CIRC_QUEUE_TRUNCATE_EN
    end else if (trunc_go) begin
      count_nxt = count_trunc;
`endif
    end else begin
      count_nxt = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
    end
  end

  queue_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_head (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (rdy_in),
    .clr    (clear),
    .ld     (1'b0),
    .ld_val ('0),
    .inc    (pop_acc),
    .ptr    (head_idx)
  );

  queue_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_tail (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (rdy_in),
    .clr    (clear),
    .ld     (tail_ld),
    .ld_val (tail_ld_val),
    .inc    (push_acc),
    .ptr    (tail_idx)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      count_q <= '0;
    else if (rdy_in) count_q <= count_nxt;
  end

  // Storage has no reset; a push to the same slot as a random write wins by ordering.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rst_in) begin
      if (wr_en)    mem[wr_idx]   <= wr_data;
      if (push_acc) mem[tail_idx] <= push_data;
    end
  end

  assign rd_data   = mem[rd_idx];
  assign head_data = mem[head_idx];
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);

endmodule

// File: tb/tb_circ_queue.sv
// Directed plus randomized check of circ_queue against an occupancy/array reference model.
module tb_circ_queue;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rdy = 1'b1;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_idx = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_idx = '0;
  logic          trunc_en = 1'b0;
  logic [AW-1:0] trunc_tail = '0;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] head_data;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: oldest slot, occupancy, slot contents, and which slots hold known data.
  int          m_head = 0;
  int          m_cnt  = 0;
  logic [DW-1:0] m_mem [D];
  bit          m_known [D];

  circ_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .push(push), .push_data(push_data),
    .pop(pop), .clear(clear), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(rd_idx), .trunc_en(trunc_en), .trunc_tail(trunc_tail), .rd_data(rd_data),
    .head_data(head_data), .head_idx(head_idx), .tail_idx(tail_idx), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic int m_tail();
    return (m_head + m_cnt) % D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_head = 0;
    m_cnt  = 0;
  endtask

  // Apply the queue rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit push_ok, pop_ok;
    if (rst) begin
      model_reset();
      return;
    end
    if (!rdy) return;
    if (wr_en) begin
      m_mem[int'(wr_idx)]   = wr_data;
      m_known[int'(wr_idx)] = 1'b1;
    end
    if (clear) begin
      model_reset();
      return;
    end
    pop_ok  = pop && (m_cnt > 0);
    push_ok = push && ((m_cnt < D) || pop);
`ifdef CIRC_QUEUE_TRUNCATE_EN
    if (trunc_en) begin
      if (pop_ok) m_head = (m_head + 1) % D;
      m_cnt = (int'(trunc_tail) - m_head + D) % D;
      return;
    end
`endif
    if (push_ok) begin
      m_mem[m_tail()]   = push_data;
      m_known[m_tail()] = 1'b1;
    end
    if (pop_ok) m_head = (m_head + 1) % D;
    m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
  endtask

  task automatic check_all();
    chk("count", 64'(count), 64'(m_cnt));
    chk("full", 64'(full), 64'(m_cnt == D));
    chk("empty", 64'(empty), 64'(m_cnt == 0));
    chk("head_idx", 64'(head_idx), 64'(m_head));
    chk("tail_idx", 64'(tail_idx), 64'(m_tail()));
    if (m_known[m_head]) chk("head_data", 64'(head_data), 64'(m_mem[m_head]));
    if (m_known[int'(rd_idx)]) chk("rd_data", 64'(rd_data), 64'(m_mem[int'(rd_idx)]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    rdy = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; wr_en = 1'b0; trunc_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_known[i] = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_head", 64'(head_idx), 64'd0);
    chk("rst_tail", 64'(tail_idx), 64'd0);

    // Fill to full, then a lone push is dropped
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = DW'(32'hA0 + i);
      step();
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_head_data", 64'(head_data), 64'hA0);
    chk("fill_tail", 64'(tail_idx), 64'd0);
    push_data = 32'hAA;
    step();
    chk("drop_full_count", 64'(count), 64'd4);

    // Push+pop while full
    push_data = 32'hB0; pop = 1'b1; rd_idx = 2'd0;
    step();
    idle();
    chk("fullpp_head", 64'(head_idx), 64'd1);
    chk("fullpp_tail", 64'(tail_idx), 64'd1);
    chk("fullpp_count", 64'(count), 64'd4);
    #1 chk("fullpp_slot0", 64'(rd_data), 64'hB0);
    chk("fullpp_head_data", 64'(head_data), 64'hA1);

    // Drain, then push+pop from empty, then pop while empty
    pop = 1'b1;
    repeat (4) step();
    push = 1'b1; push_data = 32'hC0;
    step();
    chk("emptypp_count", 64'(count), 64'd1);
    chk("emptypp_head_data", 64'(head_data), 64'hC0);
    push = 1'b0;
    step();
    step();
    chk("pop_empty_count", 64'(count), 64'd0);
    idle();

    // Build 3 entries at head=1, then truncate to 2 with a concurrent push
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = DW'(32'hD0 + i);
      step();
    end
    push = 1'b0; pop = 1'b1; step(); pop = 1'b0;
    trunc_en = 1'b1; trunc_tail = 2'd2; push = 1'b1; push_data = 32'hE0;
    step();
    idle();
`ifdef CIRC_QUEUE_TRUNCATE_EN
    chk("trunc_tail", 64'(tail_idx), 64'd2);
    chk("trunc_count", 64'(count), 64'd1);
`else
    chk("notrunc_tail", 64'(tail_idx), 64'd1);
    chk("notrunc_count", 64'(count), 64'd4);
`endif

    // Random write is not forwarded to the same-cycle read
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 32'hDD; rd_idx = 2'd2;
    #1 chk("wr_old", 64'(rd_data), 64'hD2);
    step();
    wr_en = 1'b0;
    chk("wr_new", 64'(rd_data), 64'hDD);

    // Clear beats push
    clear = 1'b1; push = 1'b1; push_data = 32'hF0;
    step();
    idle();
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_empty", 64'(empty), 64'd1);

    // Global hold
    push = 1'b1; push_data = 32'h11; step();
    push_data = 32'h22; step();
    rdy = 1'b0; push = 1'b1; pop = 1'b1; clear = 1'b1;
    repeat (3) step();
    idle();
    chk("hold_count", 64'(count), 64'd2);
    chk("hold_head", 64'(head_idx), 64'd0);
    chk("hold_tail", 64'(tail_idx), 64'd2);

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    #1 chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_tail", 64'(tail_idx), 64'd0);
    rst = 1'b0;
    model_reset();
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rdy       = ($urandom % 10) != 0;
      push      = ($urandom % 2) == 0;
      push_data = $urandom;
      pop       = ($urandom % 3) == 0;
      clear     = ($urandom % 30) == 0;
      wr_en     = ($urandom % 4) == 0;
      wr_idx    = AW'($urandom);
      wr_data   = $urandom;
      rd_idx    = AW'($urandom);
      rst       = ($urandom % 80) == 0;
`ifdef CIRC_QUEUE_TRUNCATE_EN
      trunc_en = ($urandom % 6) == 0;
      begin
        int pop_ok, k;
        pop_ok = (pop && m_cnt > 0) ? 1 : 0;
        k = int'($urandom_range(0, m_cnt - pop_ok));
        trunc_tail = AW'((m_head + pop_ok + k) % D);
      end
`else
      trunc_en   = ($urandom % 2) == 0;
      trunc_tail = AW'($urandom);
`endif
      step();
    end
    rst = 1'b0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/circ_queue.md
# circ_queue

Parametrised clocked circular FIFO with random-access slot read/write, synchronous flush, and tail rollback. Serves as the common buffering primitive for the reorder buffer, load/store queue, and instruction queue. Exported slot indices act as tags that stay stable while an entry is resident. Unlike the earlier combinational queue, all state changes on the clock edge, and the block provides full/empty protection and defined simultaneous-event priority.

## Interface
- ADDR_WIDTH, 2: log2 of depth; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: entry width in bits.

- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global enable; when low, all state is held and all requests are ignored.
- push  input  1  enqueue request.
- push_data  input  DATA_WIDTH  enqueued entry.
- pop  input  1  dequeue request.
- clear  input  1  synchronous flush.
- wr_en  input  1  random-access slot write.
- wr_idx  input  ADDR_WIDTH  absolute slot index for write.
- wr_data  input  DATA_WIDTH  write data.
- rd_idx  input  ADDR_WIDTH  absolute slot index for read.
- trunc_en  input  1  tail rollback request.
- trunc_tail  input  ADDR_WIDTH  new tail slot index.
- rd_data  output  DATA_WIDTH  storage[rd_idx], combinational.
- head_data  output  DATA_WIDTH  storage[head], combinational.
- head_idx  output  ADDR_WIDTH  slot index of oldest entry.
- tail_idx  output  ADDR_WIDTH  slot index the next push writes; this is the tag for the entry.
- count  output  ADDR_WIDTH+1  number of resident entries, 0..depth.
- full  output  1  count == depth.
- empty  output  1  count == 0.

## Operation
- State: head pointer, tail pointer, count register, and storage array. Pointers wrap modulo depth.
- Storage is not reset.
- Accept rules:
  - push_ok = push && (!full || pop).
  - pop_ok = pop && !empty.
  - A push that is not accepted is silently dropped. The same applies to a pop.
- Push: storage[tail] <= push_data; tail <= tail+1.
- Pop: head <= head+1.
- Count update: count += push_ok − pop_ok.
- Full and push+pop together: both are accepted; count stays at depth, and both head and tail advance.
- Empty and push+pop together: pop is dropped, push is accepted, count becomes 1. There is no bypass.
- Random write: wr_en writes storage[wr_idx] regardless of residency. If wr_idx == tail and push_ok in the same cycle, push_data wins.
- Truncate, when compiled in:
  - tail <= trunc_tail; count <= (trunc_tail − head_next) mod depth, where head_next reflects pop_ok.
  - push is dropped.
  - trunc_tail must lie in head_next..tail. Values outside that range are undefined use and may be asserted against.
  - Truncate can never produce full.
- Priority, highest first: rst_in, !rdy_in (hold), clear, truncate, push/pop/write.
- clear: head, tail, count <= 0. All other same-cycle requests are dropped, except that wr_en still writes.

## Timing
- Reset values: head_idx = 0, tail_idx = 0, count = 0, full = 0, empty = 1. head_data and rd_data are undefined until their slot is written.
- rd_data and head_data are combinational from registered storage. Writes become visible the cycle after the edge. There is no write-to-read forwarding.
- count, full, empty, head_idx, and tail_idx are registered and update at the edge that accepts the operation.
- Asserting rst_in mid-stream zeroes the pointers and count immediately, without waiting for a clock edge. Previously pushed data remains in storage but is not resident.
- A pointer at depth−1 wraps to 0 on increment.

## Configuration
- CIRC_QUEUE_TRUNCATE_EN defined: the truncate path is built exactly as described in Operation.
- CIRC_QUEUE_TRUNCATE_EN undefined:
  - trunc_en and trunc_tail remain as ports but are ignored.
  - No truncate logic is synthesised.
  - The priority list drops the truncate level.

## Structure
- A shared package/header queue_pkg holds:
  - depth and pointer-width derivation;
  - the count-width constant (ADDR_WIDTH+1);
  - the mod-depth pointer-distance function used by truncate and by consumers that compute ages from tags.
- One sub-module is natural: queue_ptr, a wrapping ADDR_WIDTH-bit pointer register with async reset, increment, and load. It is instantiated twice, once for head and once for tail.
- Storage, count, and accept logic live in circ_queue.

## Test plan
- Reset then 4 pushes (0xA0..0xA3) at ADDR_WIDTH=2 → count 4, full=1, head_data=0xA0, tail_idx=0. A fifth push alone is dropped and count stays 4.
- From full, push 0xB0 with pop → head_idx=1, tail_idx=1, count=4, storage[0]=0xB0. Next cycle head_data=0xA1.
- From empty, push 0xC0 with pop → count 1, head_data=0xC0. A pop while empty leaves count 0.
- With 3 entries at head=1, truncate trunc_tail=2 with simultaneous push → tail_idx=2, count=1, and the push is dropped. Without the macro, the same stimulus yields tail_idx=1 (wrapped), count=4.
- Write wr_idx=2 with 0xDD while rd_idx=2 → rd_data shows the old value that cycle and 0xDD the next. clear together with push → count 0, empty=1.
- rdy_in=0 with push/pop/clear asserted for 3 cycles → no state change. Asserting rst_in between edges drops count to 0 without waiting for a clock.
